// File: rtl/lowx_mem_responder.sv
// lowx_mem_responder: single-outstanding line memory responder with fixed latency.
module lowx_mem_responder #(
    parameter int BLK_SIZE  = 128,
    parameter int XLEN      = 32,
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    input  logic                req_ready_i,
    input  logic [XLEN-1:0]     req_addr_i,
    input  logic                req_uncached_i,
    input  logic                req_rw_i,
    input  logic [1:0]          req_rw_size_i,
    input  logic [BLK_SIZE-1:0] req_data_i,
    output logic                res_valid_o,
    output logic                res_ready_o,
    output logic [BLK_SIZE-1:0] res_data_o
);
    localparam int BOFFSET = $clog2(BLK_SIZE / 8);
    localparam int IDXW    = $clog2(MEM_LINES);
    localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IDXW-1:0]     idx_q;
    logic                rw_q;
    logic [BLK_SIZE-1:0] data_q;
    logic [BLK_SIZE-1:0] mem [MEM_LINES];
    logic [IDXW-1:0]     req_idx;
    logic                unused_ok;

    // Upper address bits alias onto the same line; size and cacheability never change a full-line access.
    assign req_idx   = req_addr_i[BOFFSET +: IDXW];
    assign unused_ok = ^{req_uncached_i, req_rw_size_i, req_addr_i};

    // Transaction FSM: accept, count down the latency, hold the response until taken, then one dead cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            res_valid_o <= 1'b0;
            res_ready_o <= 1'b0;
            res_data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    res_ready_o <= 1'b1;
                    if (req_valid_i && res_ready_o) begin
                        idx_q       <= req_idx;
                        rw_q        <= req_rw_i;
                        data_q      <= req_data_i;
                        res_ready_o <= 1'b0;
                        cnt         <= CW'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            res_valid_o <= 1'b1;
                            res_data_o  <= req_rw_i ? '0 : mem[req_idx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= RESP;
                        res_valid_o <= 1'b1;
                        res_data_o  <= rw_q ? '0 : mem[idx_q];
                    end
                end
                RESP: begin
                    if (req_ready_i) begin
                        state       <= GAP;
                        res_valid_o <= 1'b0;
                        res_data_o  <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Line array: written only on the completion edge of a write, never cleared, skipped under reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == RESP && req_ready_i && rw_q) mem[idx_q] <= data_q;
    end
endmodule
